// File: rtl/div_ctrl.sv
// div_ctrl: issue/writeback controller for the pipelined 32-bit divider core behind the
// MIPS DIV/DIVU instructions.
//
// Takes operands from EX, converts signed operands to magnitudes, drives the core's
// numer/denom/clken/aclr inputs and counts its fixed latency. It then sign-corrects
// quotient/remainder into LO/HI. `busy` stalls the pipeline on HI/LO reads while a divide
// is in flight.
//
// Parameters:
//   DIV_LATENCY   enabled clock edges from operand presentation to valid core outputs
//
// Ports:
//   clock, aclr                 system clock, asynchronous active-high reset
//   start, is_signed            request (accepted only when idle), 1 = DIV / 0 = DIVU
//   op_a, op_b                  dividend / divisor, sampled with start
//   flush                       cancel the in-flight divide
//   busy, done                  divide in flight, one-cycle completion pulse
//   hi, lo                      remainder / quotient registers
//   div_numer, div_denom        registered operand magnitudes to the core
//   div_clken, div_aclr         core clock enable and pipeline clear
//   div_quotient, div_remain    core results
//
// Build option:
//   DIVZERO_FAST_EN  when defined, a zero divisor skips the core and completes in one
//                    cycle with lo = 0xFFFFFFFF and hi = op_a (raw).

module div_ctrl #(
    parameter int unsigned DIV_LATENCY = 36
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] div_numer,
    output logic [31:0] div_denom,
    output logic        div_clken,
    output logic        div_aclr,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remain
);

    localparam int unsigned CntW = (DIV_LATENCY < 1) ? 1 : $clog2(DIV_LATENCY + 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [31:0]       numer_q, numer_d;
    logic [31:0]       denom_q, denom_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              done_q, done_d;
    logic              core_clr_q, core_clr_d;

    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic              zero_fast;

    // Only DIV with a negative operand needs the two's-complement magnitude.
    assign a_mag = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    assign b_mag = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

`ifdef DIVZERO_FAST_EN
    assign zero_fast = (op_b == 32'd0);
`else
    assign zero_fast = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        numer_d    = numer_q;
        denom_d    = denom_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        core_clr_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // flush together with start squashes the request.
                if (start && !flush) begin
                    if (zero_fast) begin
                        lo_d   = 32'hFFFF_FFFF;
                        hi_d   = op_a;
                        done_d = 1'b1;
                    end else begin
                        numer_d   = a_mag;
                        denom_d   = b_mag;
                        neg_quo_d = is_signed & (op_a[31] ^ op_b[31]);
                        neg_rem_d = is_signed & op_a[31];
                        cnt_d     = CntW'(DIV_LATENCY);
                        state_d   = StRun;
                    end
                end
            end
            StRun: begin
                if (flush) begin
                    // Squash: no writeback, clear whatever the core has in flight.
                    state_d    = StIdle;
                    cnt_d      = '0;
                    core_clr_d = 1'b1;
                end else if (cnt_q == '0) begin
                    // Core outputs are valid in exactly this cycle.
                    lo_d    = neg_quo_q ? (~div_quotient + 32'd1) : div_quotient;
                    hi_d    = neg_rem_q ? (~div_remain + 32'd1) : div_remain;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            numer_q    <= '0;
            denom_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            core_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            numer_q    <= numer_d;
            denom_q    <= denom_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            core_clr_q <= core_clr_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign div_clken = (state_q == StRun);
    // Core is held cleared for as long as our own reset is asserted.
    assign div_aclr  = aclr | core_clr_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_numer = numer_q;
    assign div_denom = denom_q;

endmodule
